// File: rtl/fifo_stream_reader.sv
// Read-domain drain engine: pops a registered-read FIFO, absorbs the read latency in a
// 3-entry skid buffer and presents the words as a burst-framed valid/ready stream.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_out
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] skid_q [3];
    logic [1:0]            head_q;
    logic [1:0]            head_d;
    logic [1:0]            tail_idx;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  pend_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [BEAT_W-1:0]     beat_d;
    logic [CNT_WIDTH-1:0]  words_q;
    logic [CNT_WIDTH-1:0]  words_d;
    logic                  push;
    logic                  pop;
    logic [2:0]            credit;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // Credits count both stored words and the word still in flight from the FIFO,
    // so the pop request never looks at m_ready.
    assign credit     = {1'b0, occ_q} + {2'b00, pend_q};
    assign fifo_rd_en = !rst && enable && !fifo_empty && (credit < 3'd3);

    assign push     = pend_q;
    assign m_valid  = (occ_q != 2'd0);
    assign pop      = m_valid && m_ready;
    assign m_data   = skid_q[head_q];
    assign m_last   = m_valid && (beat_q == LAST_BEAT);
    assign words_out = words_q;

    assign tail_idx = wrap3({1'b0, head_q} + {1'b0, occ_q});

    always_comb begin
        occ_d   = occ_q;
        head_d  = head_q;
        beat_d  = beat_q;
        words_d = words_q;
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 2'd1;
        end
        if (pop) begin
            head_d  = wrap3({1'b0, head_q} + 3'd1);
            beat_d  = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
            words_d = words_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            occ_q     <= 2'd0;
            pend_q    <= 1'b0;
            head_q    <= 2'd0;
            beat_q    <= '0;
            words_q   <= '0;
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            skid_q[2] <= '0;
        end else begin
            occ_q   <= occ_d;
            pend_q  <= fifo_rd_en;
            head_q  <= head_d;
            beat_q  <= beat_d;
            words_q <= words_d;
            if (push) begin
                skid_q[tail_idx] <= fifo_rd_data;
            end
        end
    end

    // A capture into a full buffer would mean the credit rule is broken.
    skid_overflow_chk: assert property (@(posedge rd_clk) disable iff (rst)
        !(push && (occ_q == 2'd3)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small registered-read FIFO model.
module tb_fifo_stream_reader;

    logic        rd_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        m_ready;
    logic        gap;
    logic        flushFifo;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic [15:0] words_out;

    logic [7:0]  mem [0:1023];
    int          wrIdx = 0;
    int          rdIdx = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 rd_clk = ~rd_clk;

    fifo_stream_reader #(
        .DATA_WIDTH(8),
        .BURST_LEN (4),
        .CNT_WIDTH (16)
    ) dut (
        .rd_clk      (rd_clk),
        .rst         (rst),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .words_out   (words_out)
    );

    // FIFO model: data appears the cycle after a pop, flush mirrors a shared reset.
    assign fifo_empty = (rdIdx == wrIdx) || gap;

    always @(posedge rd_clk) begin
        if (flushFifo) begin
            rdIdx <= wrIdx;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= mem[rdIdx[9:0]];
            rdIdx <= rdIdx + 1;
        end
    end

    task automatic tick();
        @(negedge rd_clk);
        #1;
    endtask

    task automatic pushWord(input logic [7:0] w);
        mem[wrIdx[9:0]] = w;
        wrIdx++;
    endtask

    task automatic resetAll();
        rst = 1'b1;
        flushFifo = 1'b1;
        gap = 1'b0;
        m_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        flushFifo = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) pushWord(8'(i + 1));
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (fifo_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en);
            end
            checks++;
            if (m_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid: got %b expected 0", m_valid);
            end
        end
        checks++;
        if (m_data !== 8'h00 || m_last !== 1'b0 || words_out !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: data=%h last=%b words=%0d expected 00/0/0",
                     m_data, m_last, words_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            failures++;
            $display("FAIL first_pop: got %b expected 1", fifo_rd_en);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_n1_valid: got %b expected 0", m_valid);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h01) begin
            failures++;
            $display("FAIL latency_n2: valid=%b data=%h expected 1/01", m_valid, m_data);
        end
    endtask

    task automatic test_streaming();
        int   got = 0;
        int   firstCyc = -1;
        int   lastCyc = -1;
        logic expLast;
        resetAll();
        enable = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) pushWord(8'(8'h10 + i));
        for (int c = 0; c < 20; c++) begin
            if (m_valid && m_ready) begin
                if (firstCyc < 0) firstCyc = c;
                lastCyc = c;
                expLast = ((got % 4) == 3);
                checks++;
                if (m_data !== 8'(8'h10 + got) || m_last !== expLast) begin
                    failures++;
                    $display("FAIL stream_beat%0d: data=%h last=%b expected %h/%b",
                             got, m_data, m_last, 8'(8'h10 + got), expLast);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 8 || (lastCyc - firstCyc) != 7) begin
            failures++;
            $display("FAIL stream_throughput: words=%0d span=%0d expected 8/7",
                     got, lastCyc - firstCyc);
        end
        checks++;
        if (words_out !== 16'd8) begin
            failures++;
            $display("FAIL stream_words_out: got %0d expected 8", words_out);
        end
    endtask

    task automatic test_back_pressure();
        int pops = 0;
        int got = 0;
        resetAll();
        enable = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) pushWord(8'(8'h20 + i));
        #1;
        for (int c = 0; c < 10; c++) begin
            if (fifo_rd_en) pops++;
            if (m_valid) begin
                checks++;
                if (m_data !== 8'h20) begin
                    failures++;
                    $display("FAIL bp_hold: got %h expected 20", m_data);
                end
            end
            tick();
        end
        checks++;
        if (pops != 3 || fifo_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL bp_pops: pops=%0d rd_en=%b expected 3/0", pops, fifo_rd_en);
        end
        checks++;
        if (m_valid !== 1'b1 || m_last !== 1'b0) begin
            failures++;
            $display("FAIL bp_state: valid=%b last=%b expected 1/0", m_valid, m_last);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 30 && got < 8; c++) begin
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== 8'(8'h20 + got)) begin
                    failures++;
                    $display("FAIL bp_order%0d: got %h expected %h", got, m_data, 8'(8'h20 + got));
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 8 || words_out !== 16'd8 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: words=%0d words_out=%0d valid=%b expected 8/8/0",
                     got, words_out, m_valid);
        end
    endtask

    task automatic test_random_stall();
        logic [7:0] expv [200];
        int         got = 0;
        int         cyc = 0;
        logic       expLast;
        resetAll();
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            expv[i] = 8'($urandom);
            pushWord(expv[i]);
        end
        while (got < 200 && cyc < 4000) begin
            m_ready = 1'($urandom_range(0, 1));
            gap = ($urandom_range(0, 3) == 0);
            if (m_valid && m_ready) begin
                expLast = ((got % 4) == 3);
                checks++;
                if (m_data !== expv[got] || m_last !== expLast) begin
                    failures++;
                    $display("FAIL rand_word%0d: data=%h last=%b expected %h/%b",
                             got, m_data, m_last, expv[got], expLast);
                end
                got++;
            end
            tick();
            cyc++;
        end
        gap = 1'b0;
        tick();
        checks++;
        if (got != 200 || words_out !== 16'd200 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL rand_total: words=%0d words_out=%0d valid=%b expected 200/200/0",
                     got, words_out, m_valid);
        end
    endtask

    task automatic test_enable_drop();
        int   got = 0;
        logic expLast;
        resetAll();
        enable = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) pushWord(8'(8'h40 + i));
        #1;
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            failures++;
            $display("FAIL en_pop_a: got %b expected 1", fifo_rd_en);
        end
        tick();
        tick();
        enable = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (fifo_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL en_low_rd_en: got %b expected 0", fifo_rd_en);
            end
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== 8'(8'h40 + got)) begin
                    failures++;
                    $display("FAIL en_drain%0d: got %h expected %h", got, m_data, 8'(8'h40 + got));
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 2) begin
            failures++;
            $display("FAIL en_drain_count: got %0d expected 2", got);
        end
        enable = 1'b1;
        for (int c = 0; c < 15 && got < 6; c++) begin
            if (m_valid && m_ready) begin
                expLast = ((got % 4) == 3);
                checks++;
                if (m_data !== 8'(8'h40 + got) || m_last !== expLast) begin
                    failures++;
                    $display("FAIL en_resume%0d: data=%h last=%b expected %h/%b",
                             got, m_data, m_last, 8'(8'h40 + got), expLast);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 6 || words_out !== 16'd6) begin
            failures++;
            $display("FAIL en_total: words=%0d words_out=%0d expected 6/6", got, words_out);
        end
    endtask

    task automatic test_mid_reset();
        int   got = 0;
        logic expLast;
        resetAll();
        enable = 1'b1;
        m_ready = 1'b1;
        pushWord(8'h50);
        pushWord(8'h51);
        for (int c = 0; c < 10; c++) begin
            if (m_valid && m_ready) got++;
            tick();
        end
        checks++;
        if (got != 2 || words_out !== 16'd2) begin
            failures++;
            $display("FAIL mr_prefill: words=%0d words_out=%0d expected 2/2", got, words_out);
        end
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) pushWord(8'(8'h60 + i));
        repeat (3) tick();
        checks++;
        if (fifo_rd_en !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h60) begin
            failures++;
            $display("FAIL mr_loaded: rd_en=%b valid=%b data=%h expected 0/1/60",
                     fifo_rd_en, m_valid, m_data);
        end
        rst = 1'b1;
        flushFifo = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b0 || words_out !== 16'd0 || m_last !== 1'b0) begin
            failures++;
            $display("FAIL mr_cleared: valid=%b words_out=%0d last=%b expected 0/0/0",
                     m_valid, words_out, m_last);
        end
        rst = 1'b0;
        flushFifo = 1'b0;
        m_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 8; i++) pushWord(8'(8'h70 + i));
        for (int c = 0; c < 30 && got < 8; c++) begin
            if (m_valid && m_ready) begin
                expLast = ((got % 4) == 3);
                checks++;
                if (m_data !== 8'(8'h70 + got) || m_last !== expLast) begin
                    failures++;
                    $display("FAIL mr_burst%0d: data=%h last=%b expected %h/%b",
                             got, m_data, m_last, 8'(8'h70 + got), expLast);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 8 || words_out !== 16'd8) begin
            failures++;
            $display("FAIL mr_total: words=%0d words_out=%0d expected 8/8", got, words_out);
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        m_ready = 1'b0;
        gap = 1'b0;
        flushFifo = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_random_stall();
        test_enable_drop();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
